// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter: FSM state encoding and baud divider.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // Clocks per bit, rounded to nearest.
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO buffering CPU writes for the UART transmitter; DEPTH must be a power of two.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally at DEPTH; count disambiguates full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped UART transmitter: FIFO-buffered bytes sent as 8N1 frames, LSB first.
// Define UART_TX_PARITY_EN to add an even parity bit (8E1 frames).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic [7:0]             wdata,
    input  logic                   clr_ovf,
    output logic                   txd,
    output logic                   busy,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    localparam int DIV = uart_div(CLK_HZ, BAUD);
    localparam int CW  = $clog2(DIV);

    uart_tx_state_t state;
    logic [CW-1:0]  baud_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic [7:0]     fifo_dout;
    logic           push;
    logic           pop;
    logic           bit_end;
`ifdef UART_TX_PARITY_EN
    logic           par;
`endif

    assign bit_end = (baud_cnt == '0);
    assign push    = wr & ~full;
    // The end of a stop bit pops straight into the next start bit, so frames abut.
    assign pop     = ~empty & ((state == IDLE) | ((state == STOP) & bit_end));
    assign busy    = (state != IDLE);

    uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (wdata),
        .dout  (fifo_dout),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else if (pop) begin
            state    <= START;
            shift    <= fifo_dout;
            baud_cnt <= CW'(DIV - 1);
            txd      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= ^fifo_dout;
`endif
        end else begin
            case (state)
                IDLE: txd <= 1'b1;
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        bit_idx  <= '0;
                        baud_cnt <= CW'(DIV - 1);
                        txd      <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= CW'(DIV - 1);
                        shift    <= shift >> 1;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            txd   <= par;
`else
                            state <= STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            txd <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        baud_cnt <= CW'(DIV - 1);
                        txd      <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        txd   <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

    // A drop on the same edge as clr_ovf wins, so software never misses it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                overflow <= 1'b0;
        else if (wr && full)    overflow <= 1'b1;
        else if (clr_ovf)       overflow <= 1'b0;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle line/FIFO reference model plus directed literal checks.
module tb_uart_tx;
    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int DEPTH  = 16;
    localparam int DIV    = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       wr;
    logic [7:0] wdata;
    logic       clr_ovf;
    logic       txd;
    logic       busy;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;

    int checks   = 0;
    int failures = 0;
    logic run_cmp = 1'b0;

    uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .wdata    (wdata),
        .clr_ovf  (clr_ovf),
        .txd      (txd),
        .busy     (busy),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // reference model: accepted bytes, expected line samples one per cycle
    logic [7:0] m_fifo[$];
    logic [0:0] exp_q[$];
    logic       m_ovf;
    logic       m_full_b;
    logic       m_empty_b;
    logic [7:0] m_head;
    logic       fb [NB];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fifo.delete();
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            m_full_b  = (m_fifo.size() == DEPTH);
            m_empty_b = (m_fifo.size() == 0);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (exp_q.size() == 0 && !m_empty_b) begin
                m_head = m_fifo.pop_front();
                fb[0] = 1'b0;
                for (int i = 0; i < 8; i++) fb[1+i] = m_head[i];
`ifdef UART_TX_PARITY_EN
                fb[9] = ^m_head;
`endif
                fb[NB-1] = 1'b1;
                for (int b = 0; b < NB; b++)
                    for (int c = 0; c < DIV; c++) exp_q.push_back(fb[b]);
            end
            if (wr) begin
                if (m_full_b) m_ovf = 1'b1;
                else          m_fifo.push_back(wdata);
            end
            if (clr_ovf && !(wr && m_full_b)) m_ovf = 1'b0;
        end
    end

    // compare process
    always @(negedge clk) begin
        if (run_cmp && !rst) begin
            chk("cmp_txd",   32'(txd),   (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd1);
            chk("cmp_busy",  32'(busy),  32'(exp_q.size() > 0));
            chk("cmp_count", 32'(count), 32'(m_fifo.size()));
            chk("cmp_empty", 32'(empty), 32'(m_fifo.size() == 0));
            chk("cmp_full",  32'(full),  32'(m_fifo.size() == DEPTH));
            chk("cmp_ovf",   32'(overflow), 32'(m_ovf));
        end
    end

    // driver tasks
    logic cap_txd  [300];
    logic cap_busy [300];

    task automatic write_byte(input logic [7:0] b);
        wr = 1'b1;
        wdata = b;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int j = 0; j < n; j++) begin
            if (j > 0) @(negedge clk);
            cap_txd[j]  = txd;
            cap_busy[j] = busy;
        end
    endtask

    function automatic logic [7:0] decode(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = cap_txd[base + (i + 1) * DIV + DIV / 2];
        return b;
    endfunction

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy || !empty) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(busy || !empty), 32'd0);
        @(negedge clk);
    endtask

    logic exp55 [NB];
    int   lows;
    int   highs;

    initial begin
`ifdef UART_TX_PARITY_EN
        exp55 = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
`else
        exp55 = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif
        rst = 1'b1; wr = 1'b0; wdata = 8'h00; clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        run_cmp = 1'b1;
        @(negedge clk);

        // single 0x55 frame
        write_byte(8'h55);
        chk("w55_count", 32'(count), 32'd1);
        chk("w55_txd_pre", 32'(txd), 32'd1);
        @(negedge clk);
        capture(NB * DIV + 2);
        for (int i = 0; i < NB; i++)
            chk($sformatf("w55_bit%0d", i), 32'(cap_txd[i * DIV + DIV / 2]), 32'(exp55[i]));
        chk("w55_busy_last", 32'(cap_busy[NB * DIV - 1]), 32'd1);
        chk("w55_busy_end", 32'(cap_busy[NB * DIV]), 32'd0);
        wait_idle(50);

        // back-to-back 0xA5, 0x3C
        wr = 1'b1; wdata = 8'hA5;
        @(negedge clk);
        wdata = 8'h3C;
        @(negedge clk);
        wr = 1'b0;
        capture(2 * NB * DIV + 2);
        chk("b2b_byte0", 32'(decode(0)), 32'hA5);
        chk("b2b_byte1", 32'(decode(NB * DIV)), 32'h3C);
        chk("b2b_stop0", 32'(cap_txd[NB * DIV - 1]), 32'd1);
        chk("b2b_start1", 32'(cap_txd[NB * DIV]), 32'd0);
        chk("b2b_nogap_busy", 32'(cap_busy[NB * DIV]), 32'd1);
        wait_idle(50);

        // 0xFF: 10 low then 90 high
        write_byte(8'hFF);
        @(negedge clk);
        capture(NB * DIV + 2);
        lows = 0; highs = 0;
        for (int j = 0; j < DIV; j++) if (cap_txd[j] == 1'b0) lows++;
        for (int j = DIV; j < NB * DIV; j++) if (cap_txd[j] == 1'b1) highs++;
        chk("ff_start_low", 32'(lows), 32'(DIV));
        chk("ff_high_cycles", 32'(highs), 32'(9 * DIV));
        chk("ff_idle_after", 32'(cap_txd[NB * DIV]), 32'd1);
        wait_idle(50);

`ifdef UART_TX_PARITY_EN
        write_byte(8'h07);
        @(negedge clk);
        capture(NB * DIV + 2);
        chk("par07_bit", 32'(cap_txd[9 * DIV + DIV / 2]), 32'd1);
        chk("par07_len_busy", 32'(cap_busy[11 * DIV - 1]), 32'd1);
        chk("par07_len_end", 32'(cap_busy[11 * DIV]), 32'd0);
        wait_idle(50);
        write_byte(8'h03);
        @(negedge clk);
        capture(NB * DIV + 2);
        chk("par03_bit", 32'(cap_txd[9 * DIV + DIV / 2]), 32'd0);
        wait_idle(50);
`endif

        // overflow: DEPTH+2 consecutive writes from idle
        wr = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            wdata = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        wr = 1'b0;
        chk("ovf_count", 32'(count), 32'(DEPTH));
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        wr = 1'b1; clr_ovf = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        chk("ovf_clr_vs_drop", 32'(overflow), 32'd1);
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
        wait_idle((DEPTH + 2) * NB * DIV + 100);

        // reset in the middle of a frame with bytes queued
        wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wdata = 8'(8'h10 + i);
            @(negedge clk);
        end
        wr = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_txd", 32'(txd), 32'd1);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lows = 0;
        for (int j = 0; j < 3 * NB * DIV; j++) begin
            @(negedge clk);
            if (txd == 1'b0) lows++;
        end
        chk("mid_rst_no_frames", 32'(lows), 32'd0);

        // randomized traffic
        for (int ph = 0; ph < 6; ph++) begin
            int p = $urandom_range(1, 4);
            for (int c = 0; c < 60; c++) begin
                wr = ($urandom_range(0, 4) < p);
                wdata = 8'($urandom_range(0, 255));
                clr_ovf = ($urandom_range(0, 15) == 0);
                @(negedge clk);
            end
            wr = 1'b0; clr_ovf = 1'b0;
            wait_idle((DEPTH + 2) * NB * DIV + 100);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
